// File: rtl/msg_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one serial message TX link between NUM_REQ byte sources.
// Grants one source per frame, passes bytes through, enforces an inter-frame gap, aborts stalled or oversized frames.
module msg_tx_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1024,
  parameter int MAX_BYTES  = 1500
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_vld_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_rdy_o,
  output logic                   tx_vld_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_last_o,
  input  logic                   tx_rdy_i,
  output logic                   tx_abort_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic [15:0]            err_cnt_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [SW-1:0] STALL_LOAD = SW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BW-1:0] MAX_B      = BW'(MAX_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ABORT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [BW-1:0]   bytes_q, bytes_d;
  logic [15:0]     err_q, err_d;

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic            g_vld, g_last, beat;
  logic [7:0]      g_data;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!pick_vld && req_vld_i[k] && (k == (int'(ptr_q) + i) % NUM_REQ)) begin
          pick_vld = 1'b1;
          pick_idx = PW'(k);
        end
      end
    end
  end

  always_comb begin
    g_vld  = 1'b0;
    g_last = 1'b0;
    g_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx_q == PW'(k)) begin
        g_vld  = req_vld_i[k];
        g_last = req_last_i[k];
        g_data = req_data_i[8*k +: 8];
      end
    end
  end

  assign beat = g_vld & tx_rdy_i;

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    stall_d    = stall_q;
    gap_d      = gap_q;
    bytes_d    = bytes_q;
    err_d      = err_q;
    req_rdy_o  = '0;
    tx_vld_o   = 1'b0;
    tx_data_o  = '0;
    tx_last_o  = 1'b0;
    tx_abort_o = 1'b0;
    grant_o    = '0;
    busy_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gidx_d  = pick_idx;
          ptr_d   = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          stall_d = STALL_LOAD;
          bytes_d = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        busy_o    = 1'b1;
        tx_vld_o  = g_vld;
        tx_data_o = g_data;
        tx_last_o = g_last;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (gidx_q == PW'(k)) begin
            grant_o[k]   = 1'b1;
            req_rdy_o[k] = tx_rdy_i;
          end
        end
        // Backpressure with valid high reloads the stall timer, so it never counts.
        stall_d = g_vld ? STALL_LOAD : stall_q - 1'b1;
        if (beat) bytes_d = bytes_q + 1'b1;
        if (beat && g_last) begin
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          gap_d   = GAP_LOAD;
        end else if ((!g_vld && stall_q == '0) || (beat && (bytes_q + 1'b1) == MAX_B)) begin
          state_d = S_ABORT;
          if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
        end
      end
      S_ABORT: begin
        busy_o     = 1'b1;
        tx_abort_o = 1'b1;
        state_d    = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        gap_d      = GAP_LOAD;
      end
      S_GAP: begin
        busy_o = 1'b1;
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_cnt_o = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      gap_q   <= '0;
      bytes_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
      bytes_q <= bytes_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Directed bench for msg_tx_arbiter: bench-side source drivers plus an output monitor,
// one task per scenario with inline comparisons against hand-computed values.
module tb_msg_tx_arbiter;
  localparam int N    = 3;
  localparam int GAP  = 16;
  localparam int TMO  = 64;
  localparam int MAXB = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_vld_i = '0;
  logic [N*8-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_rdy_o;
  logic           tx_vld_o;
  logic [7:0]     tx_data_o;
  logic           tx_last_o;
  logic           tx_rdy_i = 1'b1;
  logic           tx_abort_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic [15:0]    err_cnt_o;

  msg_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .req_vld_i(req_vld_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_rdy_o(req_rdy_o), .tx_vld_o(tx_vld_o), .tx_data_o(tx_data_o), .tx_last_o(tx_last_o),
    .tx_rdy_i(tx_rdy_i), .tx_abort_o(tx_abort_o), .grant_o(grant_o), .busy_o(busy_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         s_len[N], s_pos[N], s_stall_at[N], s_stall_left[N];
  bit         s_act[N], xfer_s[N], stall_s[N];
  logic [7:0] s_base[N];

  logic [7:0] tx_log[$];
  int         grant_seq[$], gap_len[$];
  int         n_last, last_pos, n_abort, abort_stall, stall_run, cur_gap, last_g, n_gchg;
  bit         abort_now;
  logic [N-1:0] prev_grant;

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic drive_srcs();
    for (int k = 0; k < N; k++) begin
      bit stl;
      stl = s_act[k] && s_pos[k] == s_stall_at[k] && s_stall_left[k] > 0;
      req_vld_i[k]         = s_act[k] && !stl;
      req_data_i[8*k +: 8] = s_base[k] + 8'(s_pos[k]);
      req_last_i[k]        = s_act[k] && (s_pos[k] == s_len[k] - 1);
    end
  endtask

  task automatic start_frame(input int k, input int len, input logic [7:0] base,
                             input int stall_at, input int stall_len);
    s_len[k] = len; s_pos[k] = 0; s_base[k] = base; s_act[k] = 1'b1;
    s_stall_at[k] = stall_at; s_stall_left[k] = stall_len;
    drive_srcs();
  endtask

  task automatic clear_mon();
    tx_log.delete(); grant_seq.delete(); gap_len.delete();
    n_last = 0; last_pos = 0; n_abort = 0; abort_stall = 0; stall_run = 0;
    cur_gap = 0; last_g = 0; n_gchg = 0; prev_grant = '0;
  endtask

  // Samples at the falling edge, updates the source models just after the rising edge.
  task automatic tick();
    @(negedge clk);
    abort_now = 1'b0;
    for (int k = 0; k < N; k++) begin
      xfer_s[k]  = req_vld_i[k] & req_rdy_o[k];
      stall_s[k] = s_act[k] && s_pos[k] == s_stall_at[k] && s_stall_left[k] > 0;
    end
    if (tx_vld_o && tx_rdy_i) begin
      tx_log.push_back(tx_data_o);
      if (tx_last_o) begin n_last++; last_pos = tx_log.size(); end
    end
    if (tx_abort_o) begin n_abort++; abort_stall = stall_run; abort_now = 1'b1; end
    if (grant_o != '0) begin
      if (prev_grant == '0) grant_seq.push_back(oh_idx(grant_o));
      else if (grant_o != prev_grant) n_gchg++;
      last_g = oh_idx(grant_o);
    end
    if (grant_o != '0 && !tx_vld_o) stall_run++; else stall_run = 0;
    if (busy_o && grant_o == '0 && !tx_abort_o) cur_gap++;
    else if (cur_gap > 0) begin gap_len.push_back(cur_gap); cur_gap = 0; end
    prev_grant = grant_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (xfer_s[k]) begin
        s_pos[k]++;
        if (s_pos[k] >= s_len[k]) s_act[k] = 1'b0;
      end
      if (stall_s[k]) s_stall_left[k]--;
    end
    if (abort_now && last_g >= 0) s_act[last_g] = 1'b0;
    drive_srcs();
  endtask

  task automatic run_until_idle(input int maxc);
    int c = 0;
    bit any;
    any = 1'b0;
    for (int k = 0; k < N; k++) any |= s_act[k];
    while ((any || busy_o) && c < maxc) begin
      tick();
      c++;
      any = 1'b0;
      for (int k = 0; k < N; k++) any |= s_act[k];
    end
    checks++;
    if (c >= maxc) begin errors++; $display("FAIL idle_timeout: still busy after %0d cycles", c); end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_rdy_i = 1'b1;
    for (int k = 0; k < N; k++) begin s_act[k] = 1'b0; s_pos[k] = 0; s_stall_at[k] = -1; end
    drive_srcs();
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL rst_grant: got %b exp 000", grant_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
    checks++; if (tx_vld_o !== 1'b0 || tx_last_o !== 1'b0 || tx_abort_o !== 1'b0)
      begin errors++; $display("FAIL rst_tx_flags: got vld%b last%b abort%b exp 000", tx_vld_o, tx_last_o, tx_abort_o); end
    checks++; if (req_rdy_o !== 3'b000) begin errors++; $display("FAIL rst_rdy: got %b exp 000", req_rdy_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", tx_data_o); end
    checks++; if (err_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_err: got %0d exp 0", err_cnt_o); end
  endtask

  task automatic test_single();
    bit bad;
    do_reset();
    start_frame(1, 4, 8'h10, -1, 0);
    checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL single_latency: got %b exp 000", grant_o); end
    tick();
    checks++; if (grant_o !== 3'b010) begin errors++; $display("FAIL single_grant: got %b exp 010", grant_o); end
    checks++; if (tx_vld_o !== 1'b1 || tx_data_o !== 8'h10 || req_rdy_o !== 3'b010)
      begin errors++; $display("FAIL single_first: got vld%b data%h rdy%b exp 1 10 010", tx_vld_o, tx_data_o, req_rdy_o); end
    run_until_idle(100);
    bad = tx_log.size() != 4;
    for (int i = 0; i < tx_log.size() && i < 4; i++) if (tx_log[i] !== 8'(8'h10 + i)) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL single_bytes: got %0d bytes exp 10..13", tx_log.size()); end
    checks++; if (n_last != 1 || last_pos != 4) begin errors++; $display("FAIL single_last: got n%0d pos%0d exp 1 4", n_last, last_pos); end
    checks++; if (gap_len.size() != 1 || gap_len[0] != GAP)
      begin errors++; $display("FAIL single_gap: got n%0d len%0d exp 1 %0d", gap_len.size(), (gap_len.size() > 0) ? gap_len[0] : -1, GAP); end
  endtask

  task automatic test_round_robin();
    bit bad;
    int exp_g[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) start_frame(k, 2, 8'(8'h20 + 8'h10 * k), -1, 0);
      run_until_idle(300);
    end
    bad = grant_seq.size() != 6;
    for (int i = 0; i < grant_seq.size() && i < 6; i++) if (grant_seq[i] != exp_g[i]) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL rr_order: got %0d grants exp 0,1,2,0,1,2", grant_seq.size()); end
    bad = tx_log.size() != 12;
    for (int i = 0; i < tx_log.size() && i < 12; i++)
      if (tx_log[i] !== 8'(8'h20 + 8'h10 * ((i / 2) % 3) + (i % 2))) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL rr_bytes: got %0d bytes exp 12 in rr order", tx_log.size()); end
    bad = gap_len.size() != 6;
    foreach (gap_len[i]) if (gap_len[i] != GAP) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL rr_gaps: got %0d gaps exp 6 of %0d", gap_len.size(), GAP); end
    checks++; if (n_gchg != 0) begin errors++; $display("FAIL rr_grant_stable: got %0d changes exp 0", n_gchg); end
  endtask

  task automatic test_backpressure();
    bit bad;
    do_reset();
    start_frame(0, 4, 8'h40, -1, 0);
    tick();
    tick();
    tx_rdy_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (tx_vld_o !== 1'b1 || tx_data_o !== 8'h41 || req_rdy_o !== 3'b000)
        begin errors++; $display("FAIL bp_hold: got vld%b data%h rdy%b exp 1 41 000", tx_vld_o, tx_data_o, req_rdy_o); end
    end
    tx_rdy_i = 1'b1;
    tick();
    tx_rdy_i = 1'b0;
    for (int i = 0; i < TMO + 8; i++) tick();
    checks++; if (tx_data_o !== 8'h42 || grant_o !== 3'b001 || n_abort != 0)
      begin errors++; $display("FAIL bp_long: got data%h grant%b aborts%0d exp 42 001 0", tx_data_o, grant_o, n_abort); end
    tx_rdy_i = 1'b1;
    run_until_idle(100);
    bad = tx_log.size() != 4;
    for (int i = 0; i < tx_log.size() && i < 4; i++) if (tx_log[i] !== 8'(8'h40 + i)) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL bp_bytes: got %0d bytes exp 40..43", tx_log.size()); end
    checks++; if (n_abort != 0 || err_cnt_o !== 16'd0) begin errors++; $display("FAIL bp_abort: got %0d/%0d exp 0/0", n_abort, err_cnt_o); end
  endtask

  task automatic test_timeout();
    bit bad;
    do_reset();
    start_frame(2, 6, 8'h50, 2, TMO + 10);
    tick();
    start_frame(0, 2, 8'h60, -1, 0);
    run_until_idle(400);
    checks++; if (n_abort != 1) begin errors++; $display("FAIL to_pulses: got %0d exp 1", n_abort); end
    checks++; if (abort_stall != TMO) begin errors++; $display("FAIL to_delay: got %0d exp %0d", abort_stall, TMO); end
    checks++; if (err_cnt_o !== 16'd1) begin errors++; $display("FAIL to_err: got %0d exp 1", err_cnt_o); end
    checks++; if (grant_seq.size() != 2 || grant_seq[0] != 2 || grant_seq[1] != 0)
      begin errors++; $display("FAIL to_next_grant: got %0d grants exp 2 then 0", grant_seq.size()); end
    bad = tx_log.size() != 4;
    if (!bad) bad = tx_log[0] !== 8'h50 || tx_log[1] !== 8'h51 || tx_log[2] !== 8'h60 || tx_log[3] !== 8'h61;
    checks++; if (bad) begin errors++; $display("FAIL to_bytes: got %0d bytes exp 50 51 60 61", tx_log.size()); end
    checks++; if (gap_len.size() != 2 || gap_len[0] != GAP)
      begin errors++; $display("FAIL to_gap: got %0d gaps exp 2, first %0d", gap_len.size(), GAP); end
  endtask

  task automatic test_max_len();
    bit bad;
    do_reset();
    start_frame(1, 8, 8'h70, -1, 0);
    run_until_idle(100);
    bad = tx_log.size() != 8;
    for (int i = 0; i < tx_log.size() && i < 8; i++) if (tx_log[i] !== 8'(8'h70 + i)) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL max8_bytes: got %0d bytes exp 8", tx_log.size()); end
    checks++; if (n_abort != 0 || n_last != 1 || err_cnt_o !== 16'd0)
      begin errors++; $display("FAIL max8_ok: got abort%0d last%0d err%0d exp 0 1 0", n_abort, n_last, err_cnt_o); end
    clear_mon();
    start_frame(1, 9, 8'h80, -1, 0);
    run_until_idle(100);
    checks++; if (tx_log.size() != 8 || tx_log[7] !== 8'h87)
      begin errors++; $display("FAIL max9_bytes: got %0d bytes exp 8 ending 87", tx_log.size()); end
    checks++; if (n_abort != 1 || n_last != 0 || err_cnt_o !== 16'd1)
      begin errors++; $display("FAIL max9_abort: got abort%0d last%0d err%0d exp 1 0 1", n_abort, n_last, err_cnt_o); end
  endtask

  task automatic test_one_byte();
    do_reset();
    start_frame(0, 1, 8'h99, -1, 0);
    tick();
    checks++; if (tx_vld_o !== 1'b1 || tx_last_o !== 1'b1 || tx_data_o !== 8'h99)
      begin errors++; $display("FAIL one_first: got vld%b last%b data%h exp 1 1 99", tx_vld_o, tx_last_o, tx_data_o); end
    run_until_idle(100);
    checks++; if (tx_log.size() != 1 || n_last != 1 || n_abort != 0)
      begin errors++; $display("FAIL one_frame: got bytes%0d last%0d abort%0d exp 1 1 0", tx_log.size(), n_last, n_abort); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    start_frame(1, 6, 8'hA0, -1, 0);
    tick();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    checks++; if (grant_o !== 3'b000 || busy_o !== 1'b0 || tx_vld_o !== 1'b0 || req_rdy_o !== 3'b000 ||
                  tx_abort_o !== 1'b0 || tx_data_o !== 8'h00 || tx_last_o !== 1'b0)
      begin errors++; $display("FAIL mrst_outputs: got grant%b busy%b vld%b rdy%b abort%b data%h", grant_o, busy_o, tx_vld_o, req_rdy_o, tx_abort_o, tx_data_o); end
    rst = 1'b0;
    s_act[1] = 1'b0;
    drive_srcs();
    start_frame(1, 2, 8'hB0, -1, 0);
    start_frame(2, 2, 8'hC0, -1, 0);
    tick();
    checks++; if (grant_o !== 3'b010) begin errors++; $display("FAIL mrst_ptr: got %b exp 010", grant_o); end
    run_until_idle(200);
    checks++; if (n_abort != 0 || err_cnt_o !== 16'd0) begin errors++; $display("FAIL mrst_abort: got %0d/%0d exp 0/0", n_abort, err_cnt_o); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin s_act[k] = 1'b0; s_stall_at[k] = -1; end
    clear_mon();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_max_len();
    test_one_byte();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
